// File: rtl/fft_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl_if
// Purpose : bundles the four streams that pass through fft_frame_ctrl.
//   in_*         : unframed sample stream into the sequencer
//   fft_sink_*   : framed sample stream to the FFT core sink port
//   fft_source_* : result stream from the FFT core source port
//   out_*        : tagged result stream (bin index, block exponent)
// Modports:
//   master : the frame controller's view
//   slave  : the environment's view (sample producer, FFT core, result consumer)
// ---------------------------------------------------------------------------
interface fft_frame_ctrl_if #(
  parameter int DW    = 12,
  parameter int LOG2N = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_real;
  logic [DW-1:0]    in_imag;

  logic             fft_sink_valid;
  logic             fft_sink_ready;
  logic             fft_sink_sop;
  logic             fft_sink_eop;
  logic [DW-1:0]    fft_sink_real;
  logic [DW-1:0]    fft_sink_imag;
  logic [1:0]       fft_sink_error;

  logic             fft_source_valid;
  logic             fft_source_ready;
  logic             fft_source_sop;
  logic             fft_source_eop;
  logic [1:0]       fft_source_error;
  logic [5:0]       fft_source_exp;
  logic [DW-1:0]    fft_source_real;
  logic [DW-1:0]    fft_source_imag;

  logic             out_valid;
  logic             out_ready;
  logic             out_sop;
  logic             out_eop;
  logic [DW-1:0]    out_real;
  logic [DW-1:0]    out_imag;
  logic [LOG2N-1:0] out_index;
  logic [5:0]       out_exp;

  modport master (
    input  in_valid, in_real, in_imag,
    output in_ready,
    output fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag,
           fft_sink_error,
    input  fft_sink_ready,
    input  fft_source_valid, fft_source_sop, fft_source_eop, fft_source_error,
           fft_source_exp, fft_source_real, fft_source_imag,
    output fft_source_ready,
    output out_valid, out_sop, out_eop, out_real, out_imag, out_index, out_exp,
    input  out_ready
  );

  modport slave (
    output in_valid, in_real, in_imag,
    input  in_ready,
    input  fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag,
           fft_sink_error,
    output fft_sink_ready,
    output fft_source_valid, fft_source_sop, fft_source_eop, fft_source_error,
           fft_source_exp, fft_source_real, fft_source_imag,
    input  fft_source_ready,
    input  out_valid, out_sop, out_eop, out_real, out_imag, out_index, out_exp,
    output out_ready
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl
// Purpose : frames an unframed complex sample stream into FFT_LEN-sample
//           frames for a streaming FFT core, tags the core's results with bin
//           index and block exponent, checks result-frame integrity and
//           tracks frames in flight inside the core.
// Ports   :
//   clk, reset_n                          clock, async active-low reset
//   cfg_enable/cfg_continuous/cfg_inverse enable, auto-restart, inverse FFT
//   start                                 single-shot frame request pulse
//   err_clr                               clears err_flag/err_code
//   bus (master)                          in_*, fft_sink_*, fft_source_*, out_*
//   fft_inverse                           inverse flag latched per frame
//   busy                                  feeding or frames still in the core
//   frame_done                            pulse after each result-frame eop
//   err_flag, err_code                    sticky first integrity error
//                                         (01 sop, 10 eop, 11 core error)
// ---------------------------------------------------------------------------
module fft_frame_ctrl #(
  parameter int DW           = 12,
  parameter int FFT_LEN      = 1024,
  parameter int LOG2N        = 10,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_enable,
  input  logic               cfg_continuous,
  input  logic               cfg_inverse,
  input  logic               start,
  input  logic               err_clr,
  fft_frame_ctrl_if.master   bus,
  output logic               fft_inverse,
  output logic               busy,
  output logic               frame_done,
  output logic               err_flag,
  output logic [1:0]         err_code
);

  localparam int               IW   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(FFT_LEN - 1);

  typedef enum logic {IDLE, FEED} state_t;

  state_t           state, state_nxt;
  logic [LOG2N-1:0] count;
  logic [LOG2N-1:0] index;
  logic [IW-1:0]    inflight;
  logic             launch;
  logic             sink_hs, sink_eop_hs;
  logic             src_hs, src_eop_hs, src_dec;
  logic             new_err;
  logic [1:0]       new_code;

  assign sink_hs     = (state == FEED) && bus.in_valid && bus.fft_sink_ready;
  assign sink_eop_hs = sink_hs && (count == LAST);
  assign src_hs      = bus.fft_source_valid && bus.out_ready;
  assign src_eop_hs  = src_hs && bus.fft_source_eop;
  // A stray source eop with nothing in flight must not wrap the counter.
  assign src_dec     = src_eop_hs && (inflight != '0);

  // Data paths are pure pass-throughs; only the handshakes are gated by state.
  assign bus.fft_sink_real    = bus.in_real;
  assign bus.fft_sink_imag    = bus.in_imag;
  assign bus.fft_sink_error   = 2'b00;
  assign bus.fft_source_ready = bus.out_ready;
  assign bus.out_valid        = bus.fft_source_valid;
  assign bus.out_sop          = bus.fft_source_sop;
  assign bus.out_eop          = bus.fft_source_eop;
  assign bus.out_real         = bus.fft_source_real;
  assign bus.out_imag         = bus.fft_source_imag;
  assign bus.out_exp          = bus.fft_source_exp;
  assign bus.out_index        = index;

  assign busy = (state == FEED) || (inflight != '0);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt          = state;
    launch             = 1'b0;
    bus.in_ready       = 1'b0;
    bus.fft_sink_valid = 1'b0;
    bus.fft_sink_sop   = 1'b0;
    bus.fft_sink_eop   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_enable && (inflight < IW'(MAX_INFLIGHT)) && (start || cfg_continuous)) begin
          state_nxt = FEED;
          launch    = 1'b1;
        end
      end
      FEED: begin
        bus.fft_sink_valid = bus.in_valid;
        bus.in_ready       = bus.fft_sink_ready;
        bus.fft_sink_sop   = (count == '0);
        bus.fft_sink_eop   = (count == LAST);
        // Leaving only on the eop handshake means dropping enable or
        // continuous mid-frame never truncates the frame.
        if (sink_eop_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Integrity check of one source beat; a core error outranks framing errors.
  always_comb begin
    new_err  = 1'b0;
    new_code = 2'b00;
    if (src_hs) begin
      if (bus.fft_source_error != 2'b00) begin
        new_err  = 1'b1;
        new_code = 2'b11;
      end else if (bus.fft_source_eop != (index == LAST)) begin
        new_err  = 1'b1;
        new_code = 2'b10;
      end else if (bus.fft_source_sop != (index == '0)) begin
        new_err  = 1'b1;
        new_code = 2'b01;
      end
    end
  end

  // NOTE: reset is asynchronous so a mid-frame reset takes effect at once,
  // together with the core that shares reset_n; all state uses non-blocking
  // assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      fft_inverse <= 1'b0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        count       <= '0;
        fft_inverse <= cfg_inverse;
      end else if (sink_hs) begin
        count <= sink_eop_hs ? '0 : count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= '0;
    end else begin
      case ({sink_eop_hs, src_dec})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= src_eop_hs;
      if (src_hs) begin
        // sop re-anchors the index even inside a corrupted frame.
        if (bus.fft_source_sop)      index <= LOG2N'(1);
        else if (bus.fft_source_eop) index <= '0;
        else                         index <= index + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flag <= 1'b0;
      err_code <= 2'b00;
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_code <= 2'b00;
    end else if (new_err && !err_flag) begin
      err_flag <= 1'b1;
      err_code <= new_code;
    end
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer between a sample stream and the streaming FFT core. Cuts an unframed complex sample stream into FFT_LEN-sample frames and drives the core's sink port with sop/eop, valid/ready and a per-frame latched inverse flag. Receives the core's source stream, tags each output bin with its index and block exponent, checks frame integrity, and tracks frames in flight. Sits directly around the FFT core instance in the top level.

## Interface
- DW, 12, sample width of real/imag on every stream.
- FFT_LEN, 1024, points per frame; must be a power of two ≥ 8.
- LOG2N, 10, log2(FFT_LEN).
- MAX_INFLIGHT, 2, maximum frames accepted by the core but not yet fully emitted.
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_enable / cfg_continuous / cfg_inverse  in  1 each  enable; auto-restart frames; inverse FFT.
- start  in  1  one-cycle pulse: run one frame (single-shot mode).
- err_clr  in  1  clears err_flag/err_code.
- in_valid / in_ready  in / out  1  input sample handshake.
- in_real, in_imag  in  DW  input sample.
- fft_sink_valid / fft_sink_ready  out / in  1  core sink handshake.
- fft_sink_sop, fft_sink_eop  out  1  frame delimiters.
- fft_sink_real, fft_sink_imag  out  DW  sample to core.
- fft_sink_error  out  2  constant 0.
- fft_inverse  out  1  inverse flag latched for current frame.
- fft_source_valid / fft_source_ready  in / out  1  core source handshake.
- fft_source_sop, fft_source_eop  in  1; fft_source_error  in  2; fft_source_exp  in  6.
- fft_source_real, fft_source_imag  in  DW.
- out_valid / out_ready  out / in  1  result handshake.
- out_sop, out_eop  out  1; out_real, out_imag  out  DW; out_index  out  LOG2N  bin number; out_exp  out  6  block exponent.
- busy  out  1; frame_done  out  1  one-cycle pulse; err_flag  out  1  sticky; err_code  out  2.

## Operation
- Sink FSM: IDLE, FEED.
  - IDLE→FEED when cfg_enable && inflight<MAX_INFLIGHT && (start || cfg_continuous). Latch fft_inverse←cfg_inverse, sample count←0.
  - FEED: fft_sink_valid=in_valid, in_ready=fft_sink_ready, data passes combinationally. sop=(count==0), eop=(count==FFT_LEN-1). Count advances only on handshake.
  - Eop handshake → IDLE; re-entry is the same IDLE rule, evaluated next cycle.
  - In IDLE: in_ready=0, fft_sink_valid=0.
  - cfg_enable or cfg_continuous dropping mid-frame never truncates; the frame completes.
  - start in FEED is ignored; start with cfg_enable=0 is ignored.
- inflight counter: +1 on sink eop handshake, −1 on source eop handshake; both in one cycle → unchanged.
- Source path: out_*=fft_source_* pass-through, fft_source_ready=out_ready. out_index counts source handshakes, resets to 0 after eop. out_exp is fft_source_exp.
- Checks on each source handshake, setting err_flag and err_code (first error wins until err_clr):
  - 01: sop at index≠0 or no sop at index 0.
  - 10: eop at index≠FFT_LEN-1 or missing at FFT_LEN-1.
  - 11: fft_source_error≠0.
  - Index always resyncs to 1 after a sop.
- busy = (state==FEED) || inflight≠0.
- err_clr has priority over a simultaneous new error.

## Timing
- Reset values: state IDLE, count 0, inflight 0, out_index 0, fft_inverse 0, frame_done 0, err_flag 0, err_code 0. All handshake outputs 0 except combinational pass-throughs, which follow their inputs.
- Sink and source paths: zero-cycle latency.
- IDLE→FEED: one cycle after qualifying condition. Back-to-back continuous frames leave exactly one IDLE cycle between them.
- frame_done: pulses the cycle after the source eop handshake. err_flag rises the cycle after the offending handshake.
- Reset asserted mid-frame returns everything to reset values immediately. The core shares reset_n.

## Test plan
- Single shot, FFT_LEN=16: start pulse, 16 samples with in_valid constant → sop on sample 0, eop on sample 15, then IDLE with in_ready=0. The 17th sample is not accepted.
- Backpressure: fft_sink_ready toggling 1/0 each cycle over a frame → exactly 16 handshakes, sop/eop on handshakes 0/15, count stable while stalled.
- Continuous, MAX_INFLIGHT=2, out_ready=0 → two frames enter, third waits in IDLE. Raise out_ready → third starts after the first source eop. inflight returns to 0, busy falls.
- Inverse latching: cfg_inverse toggled at sample 5 → fft_inverse unchanged until next frame start.
- Integrity: source eop injected at index 7 → err_code=10, err_flag=1 next cycle. err_clr → 0. Source_error=2'b01 → err_code=11.
- Reset at sample 9 → all outputs at reset values. A new start produces a clean frame beginning at sop.
